time_entry_parser: RTL and testbench

- Converts human-entered clock commands, arriving as one ASCII character per accepted handshake, into seconds-since-midnight timestamps (0..86399).
- Drives the set and alarm inputs of the counter and alarm blocks, replacing simulated user input.
- It is the input-side counterpart of the output formatter: "hh:mm:ssXM" text in, timestamp out.

---
 rtl/time_entry_if.sv | 39 +++
 rtl/time_entry_parser.sv | 170 +++++++++++++++++
 tb/tb_time_entry_parser.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_entry_if.sv
// time_entry_if
//   Bundles the character input handshake and the timestamp outputs of the
//   clock-command parser.
//
// Handshake: in_char is transferred on a rising clock edge where both
// in_valid and in_ready are high. While in_valid is high and in_ready is low,
// the sender holds in_char stable. in_ready does not depend on in_valid.
//
//   in_char     [7:0]  ASCII character from sender
//   in_valid           in_char is valid
//   in_ready           parser can accept this cycle
//   set_flag           one-cycle pulse: load set_time into the counter
//   set_time    [16:0] last committed T timestamp
//   alarm_flag         alarm enable level
//   alarm_time  [16:0] last committed A timestamp
//   cmd_error          one-cycle pulse on a malformed command
//
//   master: character sender / timestamp consumer
//   slave : the parser
interface time_entry_if;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic        cmd_error;

  modport master (
    output in_char, in_valid,
    input  in_ready, set_flag, set_time, alarm_flag, alarm_time, cmd_error
  );

  modport slave (
    input  in_char, in_valid,
    output in_ready, set_flag, set_time, alarm_flag, alarm_time, cmd_error
  );
endinterface

// File: rtl/time_entry_parser.sv
// time_entry_parser
//   Turns typed clock commands ("Thh:mm:ssXM", "Ahh:mm:ssXM", "E", "D", each
//   ended by TERM_CHAR) into seconds-since-midnight timestamps that drive the
//   counter's set port and the alarm block.
//
//   clock      single design clock, posedge
//   reset      synchronous, active-high
//   bus        time_entry_if.slave: character handshake in, timestamps out
//   state_dbg  current FSM state encoding, for observation only
module time_entry_parser #(
  parameter logic [7:0]  TERM_CHAR   = 8'h0A,
  parameter logic [7:0]  IGNORE_CHAR = 8'h0D,
  parameter int unsigned COUNTER_MAX = 86399
) (
  input  logic        clock,
  input  logic        reset,
  time_entry_if.slave bus,
  output logic [3:0]  state_dbg
);

  localparam logic [16:0] MAX_TS = 17'(COUNTER_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_H1, S_H0, S_C1, S_M1, S_M0, S_C2, S_S1, S_S0,
    S_AP, S_MCH, S_TERM, S_FLAG_TERM, S_COMMIT, S_ERROR
  } state_t;

  typedef enum logic [1:0] {K_T, K_A, K_E, K_D} kind_t;

  state_t      state;
  state_t      next_state;
  kind_t       kind;
  logic [3:0]  hour_r;
  logic [5:0]  min_r;
  logic [5:0]  sec_r;
  logic        pm_r;
  logic        set_flag_r;
  logic [16:0] set_time_r;
  logic        alarm_flag_r;
  logic [16:0] alarm_time_r;
  logic        cmd_error_r;

  logic [7:0]  c;
  logic [3:0]  d;
  logic        is_digit;
  logic        accept;
  logic        char_ok;
  logic [4:0]  hour_acc;
  logic [5:0]  min_acc;
  logic [5:0]  sec_acc;
  logic [4:0]  h24;
  logic [16:0] value;
  logic [16:0] value_safe;

  assign c        = bus.in_char;
  assign d        = c[3:0];          // low nibble of '0'..'9' is the digit
  assign is_digit = (c >= "0") && (c <= "9");
  assign accept   = bus.in_valid && bus.in_ready;

  // Tens digit is already held in the field register when the units arrive.
  assign hour_acc = {1'b0, hour_r} * 5'd10 + {1'b0, d};
  assign min_acc  = min_r * 6'd10 + {2'b0, d};
  assign sec_acc  = sec_r * 6'd10 + {2'b0, d};

  // 12 AM is hour 0, 12 PM is hour 12.
  assign h24   = ((hour_r == 4'd12) ? 5'd0 : {1'b0, hour_r}) + (pm_r ? 5'd12 : 5'd0);
  assign value = ({12'd0, h24} * 17'd60 + {11'd0, min_r}) * 17'd60 + {11'd0, sec_r};
  // Field checks already keep value in range; the clamp is a backstop.
  assign value_safe = (value > MAX_TS) ? MAX_TS : value;

  // Legality and successor for the fixed-position field states.
  always_comb begin
    char_ok    = 1'b0;
    next_state = state;
    case (state)
      S_H1:        begin char_ok = is_digit && (d <= 4'd1);                next_state = S_H0;     end
      S_H0:        begin char_ok = is_digit && (hour_acc >= 5'd1) && (hour_acc <= 5'd12);
                                                                             next_state = S_C1;     end
      S_C1:        begin char_ok = (c == ":");                             next_state = S_M1;     end
      S_M1:        begin char_ok = is_digit && (d <= 4'd5);                next_state = S_M0;     end
      S_M0:        begin char_ok = is_digit;                               next_state = S_C2;     end
      S_C2:        begin char_ok = (c == ":");                             next_state = S_S1;     end
      S_S1:        begin char_ok = is_digit && (d <= 4'd5);                next_state = S_S0;     end
      S_S0:        begin char_ok = is_digit;                               next_state = S_AP;     end
      S_AP:        begin char_ok = (c == "A") || (c == "P");               next_state = S_MCH;    end
      S_MCH:       begin char_ok = (c == "M");                             next_state = S_TERM;   end
      S_TERM:      begin char_ok = (c == TERM_CHAR);                       next_state = S_COMMIT; end
      S_FLAG_TERM: begin char_ok = (c == TERM_CHAR);                       next_state = S_COMMIT; end
      default:     ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      kind         <= K_T;
      hour_r       <= '0;
      min_r        <= '0;
      sec_r        <= '0;
      pm_r         <= 1'b0;
      set_flag_r   <= 1'b0;
      set_time_r   <= '0;
      alarm_flag_r <= 1'b0;
      alarm_time_r <= '0;
      cmd_error_r  <= 1'b0;
    end else begin
      set_flag_r  <= 1'b0;
      cmd_error_r <= 1'b0;
      if (state == S_COMMIT) begin
        state <= S_IDLE;
      end else if (accept && (c != IGNORE_CHAR)) begin
        case (state)
          S_IDLE: begin
            if (c == "T" || c == "A") begin
              kind  <= (c == "T") ? K_T : K_A;
              state <= S_H1;
            end else if (c == "E" || c == "D") begin
              kind  <= (c == "E") ? K_E : K_D;
              state <= S_FLAG_TERM;
            end else if (c != TERM_CHAR) begin
              cmd_error_r <= 1'b1;
              state       <= S_ERROR;
            end
          end
          S_ERROR: begin
            if (c == TERM_CHAR) state <= S_IDLE;
          end
          default: begin
            if (char_ok) begin
              state <= next_state;
              case (state)
                S_H1:   hour_r <= d;
                S_H0:   hour_r <= hour_acc[3:0];
                S_M1:   min_r  <= {2'b0, d};
                S_M0:   min_r  <= min_acc;
                S_S1:   sec_r  <= {2'b0, d};
                S_S0:   sec_r  <= sec_acc;
                S_AP:   pm_r   <= (c == "P");
                // Results land with the COMMIT state, one cycle after TERM_CHAR.
                S_TERM: begin
                  if (kind == K_T) begin
                    set_time_r <= value_safe;
                    set_flag_r <= 1'b1;
                  end else begin
                    alarm_time_r <= value_safe;
                  end
                end
                S_FLAG_TERM: alarm_flag_r <= (kind == K_E);
                default: ;
              endcase
            end else begin
              // A terminator inside a command also closes it.
              cmd_error_r <= 1'b1;
              state       <= (c == TERM_CHAR) ? S_IDLE : S_ERROR;
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = !reset && (state != S_COMMIT);
  assign bus.set_flag   = set_flag_r;
  assign bus.set_time   = set_time_r;
  assign bus.alarm_flag = alarm_flag_r;
  assign bus.alarm_time = alarm_time_r;
  assign bus.cmd_error  = cmd_error_r;
  assign state_dbg      = state;

endmodule

// File: tb/tb_time_entry_parser.sv
module tb_time_entry_parser;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  // ---------------- clock / reset ----------------
  logic       clock;
  logic       reset;
  logic [3:0] dbg_state;

  time_entry_if bus ();

  time_entry_parser dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / compare ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int n_set_pulses = 0;
  int n_err_pulses = 0;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on the command text as a whole: characters are collected into a
  // buffer, each position is checked against the grammar, and a complete
  // command is converted with plain integer arithmetic.
  typedef enum {M_IDLE, M_COLLECT, M_DISCARD} mode_t;
  mode_t       m_mode;
  logic [7:0]  cmd_b [0:11];
  int          cmd_len;
  logic        m_commit;
  logic        check_en = 1'b0;
  logic        e_set_flag, e_alarm_flag, e_cmd_error;
  logic [16:0] e_set_time, e_alarm_time;

  function automatic int dig(input logic [7:0] ch);
    return int'(ch) - 48;
  endfunction

  function automatic bit is_dig(input logic [7:0] ch);
    return (ch >= 8'h30) && (ch <= 8'h39);
  endfunction

  function automatic bit field_ok(input int pos, input logic [7:0] ch);
    int hh;
    case (pos)
      1:    return ch == "0" || ch == "1";
      2: begin
        if (!is_dig(ch)) return 1'b0;
        hh = dig(cmd_b[1]) * 10 + dig(ch);
        return hh >= 1 && hh <= 12;
      end
      3, 6: return ch == ":";
      4, 7: return ch >= "0" && ch <= "5";
      5, 8: return is_dig(ch);
      9:    return ch == "A" || ch == "P";
      10:   return ch == "M";
      default: return 1'b0;
    endcase
  endfunction

  function automatic int cmd_seconds();
    int hh, mm, ss;
    hh = dig(cmd_b[1]) * 10 + dig(cmd_b[2]);
    mm = dig(cmd_b[4]) * 10 + dig(cmd_b[5]);
    ss = dig(cmd_b[7]) * 10 + dig(cmd_b[8]);
    return ((hh % 12) + ((cmd_b[9] == "P") ? 12 : 0)) * 3600 + mm * 60 + ss;
  endfunction

  task automatic model_reset();
    m_mode       = M_IDLE;
    cmd_len      = 0;
    m_commit     = 1'b0;
    e_set_flag   = 1'b0;
    e_set_time   = '0;
    e_alarm_flag = 1'b0;
    e_alarm_time = '0;
    e_cmd_error  = 1'b0;
  endtask

  task automatic model_char(input logic [7:0] ch);
    int full_len;
    if (ch == CR) return;
    case (m_mode)
      M_IDLE: begin
        if (ch == "T" || ch == "A" || ch == "E" || ch == "D") begin
          cmd_b[0] = ch;
          cmd_len  = 1;
          m_mode   = M_COLLECT;
        end else if (ch != LF) begin
          e_cmd_error = 1'b1;
          m_mode      = M_DISCARD;
        end
      end
      M_DISCARD: if (ch == LF) m_mode = M_IDLE;
      default: begin
        full_len = (cmd_b[0] == "T" || cmd_b[0] == "A") ? 11 : 1;
        if (cmd_len == full_len) begin
          if (ch == LF) begin
            m_commit = 1'b1;
            m_mode   = M_IDLE;
            case (cmd_b[0])
              "T": begin e_set_time = 17'(cmd_seconds()); e_set_flag = 1'b1; end
              "A": e_alarm_time = 17'(cmd_seconds());
              "E": e_alarm_flag = 1'b1;
              default: e_alarm_flag = 1'b0;
            endcase
          end else begin
            e_cmd_error = 1'b1;
            m_mode      = M_DISCARD;
          end
        end else if (ch == LF) begin
          e_cmd_error = 1'b1;
          m_mode      = M_IDLE;
        end else if (field_ok(cmd_len, ch)) begin
          cmd_b[cmd_len] = ch;
          cmd_len++;
        end else begin
          e_cmd_error = 1'b1;
          m_mode      = M_DISCARD;
        end
      end
    endcase
  endtask

  // ---------------- scoreboard: per-cycle compare on negedge ----------------
  always @(negedge clock) begin
    logic ready_exp;
    ready_exp = !reset && !m_commit;
    if (check_en) begin
      check("in_ready",   17'(bus.in_ready),   17'(ready_exp));
      check("set_flag",   17'(bus.set_flag),   17'(e_set_flag));
      check("set_time",   bus.set_time,        e_set_time);
      check("alarm_flag", 17'(bus.alarm_flag), 17'(e_alarm_flag));
      check("alarm_time", bus.alarm_time,      e_alarm_time);
      check("cmd_error",  17'(bus.cmd_error),  17'(e_cmd_error));
      if (bus.set_flag === 1'b1)  n_set_pulses++;
      if (bus.cmd_error === 1'b1) n_err_pulses++;
    end
    if (reset) begin
      model_reset();
      check_en = 1'b1;
    end else begin
      e_set_flag  = 1'b0;
      e_cmd_error = 1'b0;
      m_commit    = 1'b0;
      if (bus.in_valid && ready_exp) model_char(bus.in_char);
    end
  end

  // ---------------- driver tasks (all drives at posedge + 2) ----------------
  task automatic send_char(input logic [7:0] ch);
    bit ready;
    bus.in_char  = ch;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      ready = bus.in_ready;
      @(posedge clock);
      #2;
      if (ready) return;
    end
    n_vec++;
    n_miss++;
    $display("FAIL handshake: char %0d not accepted within 50 cycles", ch);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_cmd(input string s);
    send_str(s);
    send_char(LF);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #2;
  endtask

  // ---------------- directed stimulus with literal pins ----------------
  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    check("rst_set_time",   bus.set_time,   17'd0);
    check("rst_alarm_time", bus.alarm_time, 17'd0);
    check("rst_alarm_flag", 17'(bus.alarm_flag), 17'd0);

    // Set commands across the AM/PM boundaries.
    send_cmd("T12:00:00AM");
    check("lit_set_flag_0", 17'(bus.set_flag), 17'd1);
    check("lit_set_time_0", bus.set_time, 17'd0);
    idle(2);
    send_cmd("T12:30:15PM");
    check("lit_set_time_45015", bus.set_time, 17'd45015);
    idle(2);
    send_cmd("T11:59:59PM");
    check("lit_set_time_max", bus.set_time, 17'd86399);
    idle(2);

    // Alarm load, enable, disable.
    send_cmd("A07:05:09AM");
    check("lit_alarm_time", bus.alarm_time, 17'd25509);
    check("lit_no_set_flag", 17'(bus.set_flag), 17'd0);
    idle(1);
    send_cmd("E");
    check("lit_alarm_on", 17'(bus.alarm_flag), 17'd1);
    idle(1);
    send_cmd("D");
    check("lit_alarm_off", 17'(bus.alarm_flag), 17'd0);
    check("lit_alarm_kept", bus.alarm_time, 17'd25509);
    idle(2);

    // Illegal hour, then a valid early-morning time.
    send_cmd("T13:00:00AM");
    idle(2);
    check("lit_set_time_kept", bus.set_time, 17'd86399);
    send_cmd("T01:00:00AM");
    check("lit_set_time_3600", bus.set_time, 17'd3600);
    idle(2);

    // Early terminator, then CR ignored before LF.
    send_cmd("T12");
    idle(2);
    send_str("T12:00:01AM");
    send_char(CR);
    send_char(LF);
    check("lit_set_time_1", bus.set_time, 17'd1);
    idle(2);

    // Back-to-back with in_valid held high.
    send_cmd("E");
    check("lit_commit_ready_low", 17'(bus.in_ready), 17'd0);
    check("lit_alarm_on_2", 17'(bus.alarm_flag), 17'd1);
    send_cmd("T10:00:00AM");
    check("lit_set_time_36000", bus.set_time, 17'd36000);
    idle(2);

    // Reset in the middle of a command.
    send_str("T11:5");
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    check("mid_rst_set_time",   bus.set_time,   17'd0);
    check("mid_rst_alarm_time", bus.alarm_time, 17'd0);
    check("mid_rst_alarm_flag", 17'(bus.alarm_flag), 17'd0);
    send_cmd("59:59PM");
    idle(4);
    check("lit_set_time_after", bus.set_time, 17'd0);

    check("lit_set_pulses", 17'(n_set_pulses), 17'd6);
    check("lit_err_pulses", 17'(n_err_pulses), 17'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
